// File: rtl/debug_clock_monitor.sv
// debug_clock_monitor: divided/gated processor clock with pause, single-step and breakpoint, plus hex debug display
module debug_clock_monitor #(
    parameter int DIV_MAX         = 25000000,
    parameter int N_CH            = 4,
    parameter int DATA_W          = 32,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pause,
    input  logic                       step_btn,
    input  logic                       bp_en,
    input  logic [DATA_W-1:0]          bp_addr,
    input  logic [$clog2(N_CH)-1:0]    sel,
    input  logic [N_CH*DATA_W-1:0]     debug_bus,
    output logic                       mod_clk,
    output logic                       halted,
    output logic                       bp_hit,
    output logic [31:0]                cycle_count,
    output logic [7*(DATA_W/4)-1:0]    segments
);
    localparam int DIV_W = $clog2(DIV_MAX);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef enum logic [2:0] {S_RUN, S_PAUSE, S_BREAK, S_STEP_HI, S_STEP_LO} state_t;
    state_t state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DB_W-1:0] dbc_q, dbc_d;
    logic [1:0] sync_q, sync_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7*(DATA_W/4)-1:0] seg_q, seg_d;
    logic [DATA_W-1:0] ch;
    logic mod_q, mod_d, skip_q, skip_d, from_brk_q, from_brk_d, pend_q, pend_d, db_q, db_d;
    logic tick, press, step, bp_match, idle;
    always_comb begin
        tick = div_q == DIV_W'(DIV_MAX - 1);
        div_d = tick ? '0 : div_q + 1'b1;
        sync_d = {sync_q[0], step_btn};
        dbc_d = (sync_q[1] == db_q || dbc_q == DB_W'(DEBOUNCE_CYCLES - 1)) ? '0 : dbc_q + 1'b1;
        db_d = (sync_q[1] != db_q && dbc_q == DB_W'(DEBOUNCE_CYCLES - 1)) ? sync_q[1] : db_q;
        press = db_d & ~db_q;
        step = pend_q | press;
        idle = state_q == S_PAUSE || state_q == S_BREAK;
        // presses only survive while halted, and any tick consumes them
        pend_d = idle & ~tick & step;
        bp_match = bp_en && debug_bus[DATA_W-1:0] == bp_addr && !skip_q;
        state_d = state_q;
        mod_d = mod_q;
        skip_d = skip_q;
        from_brk_d = from_brk_q;
        if (tick) begin
            case (state_q)
                S_RUN: begin
                    if (pause) begin
                        mod_d = 1'b0;
                        state_d = S_PAUSE;
                    end else if (!mod_q && bp_match) begin
                        state_d = S_BREAK;
                    end else begin
                        mod_d = !mod_q;
                        skip_d = mod_q & skip_q;
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        state_d = S_RUN;
                        skip_d = 1'b1;
                    end else if (step) begin
                        state_d = S_STEP_HI;
                        mod_d = 1'b1;
                        from_brk_d = 1'b0;
                    end
                end
                S_BREAK: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else if (step) begin
                        state_d = S_STEP_HI;
                        mod_d = 1'b1;
                        from_brk_d = 1'b1;
                    end
                end
                S_STEP_HI: begin
                    state_d = S_STEP_LO;
                    mod_d = 1'b0;
                end
                S_STEP_LO: state_d = from_brk_q ? S_BREAK : S_PAUSE;
                default: state_d = S_RUN;
            endcase
        end
        cnt_d = cnt_q + 32'(mod_d & ~mod_q);
        ch = debug_bus[(32'(sel) < N_CH ? 32'(sel) : 0) * DATA_W +: DATA_W];
        seg_d = '1;
        for (int i = 0; i < DATA_W / 4; i++) seg_d[7*i +: 7] = FONT[ch[4*i +: 4]];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            div_q <= '0;
            dbc_q <= '0;
            sync_q <= '0;
            cnt_q <= '0;
            seg_q <= '1;
            mod_q <= 1'b0;
            skip_q <= 1'b0;
            from_brk_q <= 1'b0;
            pend_q <= 1'b0;
            db_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q <= div_d;
            dbc_q <= dbc_d;
            sync_q <= sync_d;
            cnt_q <= cnt_d;
            seg_q <= seg_d;
            mod_q <= mod_d;
            skip_q <= skip_d;
            from_brk_q <= from_brk_d;
            pend_q <= pend_d;
            db_q <= db_d;
        end
    end
    assign mod_clk = mod_q;
    assign halted = state_q != S_RUN;
    assign bp_hit = state_q == S_BREAK;
    assign cycle_count = cnt_q;
    assign segments = seg_q;
endmodule

// File: tb/tb_debug_clock_monitor.sv
// tb_debug_clock_monitor: scenario-driven bench for debug_clock_monitor with a segment scoreboard
module tb_debug_clock_monitor;
    logic clk = 0, reset = 1, pause = 0, step_btn = 0, bp_en = 0, mod_prev = 0;
    logic [31:0] bp_addr = 0, ch1 = 0, ch2 = 0, pc = 0;
    logic [1:0] sel = 0;
    logic [95:0] debug_bus;
    logic mod_clk, halted, bp_hit;
    logic [31:0] cycle_count;
    logic [55:0] segments;
    logic [55:0] exp_q [$];
    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int vectors = 0, miscompares = 0;
    assign debug_bus = {ch2, ch1, pc};
    debug_clock_monitor #(.DIV_MAX(4), .N_CH(3), .DATA_W(32), .DEBOUNCE_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .pause(pause), .step_btn(step_btn), .bp_en(bp_en),
        .bp_addr(bp_addr), .sel(sel), .debug_bus(debug_bus), .mod_clk(mod_clk),
        .halted(halted), .bp_hit(bp_hit), .cycle_count(cycle_count), .segments(segments)
    );
    always #5 clk = ~clk;
    // processor model: program counter advances by 4 on each mod_clk rise
    always @(posedge clk) begin
        mod_prev <= mod_clk;
        if (reset) pc <= 0;
        else if (mod_clk && !mod_prev) pc <= pc + 4;
    end
    function automatic logic [55:0] seg_of(input logic [31:0] v);
        for (int i = 0; i < 8; i++) seg_of[7*i +: 7] = font[v[4*i +: 4]];
    endfunction
    task automatic wait_mod(input logic lvl, output int cyc);
        cyc = 0;
        while (mod_clk !== lvl && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask
    task automatic count_rises(input int n, output int r);
        logic p;
        r = 0;
        p = mod_clk;
        repeat (n) begin
            @(negedge clk);
            if (mod_clk && !p) r++;
            p = mod_clk;
        end
    endtask
    task automatic pulse_watch(input int len, input int win, output int r, output int hi);
        logic p;
        r = 0;
        hi = 0;
        p = mod_clk;
        for (int i = 0; i < win; i++) begin
            step_btn = (i < len);
            @(negedge clk);
            if (mod_clk) hi++;
            if (mod_clk && !p) r++;
            p = mod_clk;
        end
        step_btn = 0;
    endtask
    task automatic wait_bp(output int c);
        c = 0;
        while (bp_hit !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
    endtask
    task automatic test_reset;
        reset = 1;
        repeat (3) @(negedge clk);
        vectors++; if (mod_clk !== 1'b0) begin miscompares++; $display("FAIL reset_mod_clk: got %b want 0", mod_clk); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
        vectors++; if (bp_hit !== 1'b0) begin miscompares++; $display("FAIL reset_bp_hit: got %b want 0", bp_hit); end
        vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
        vectors++; if (segments !== {56{1'b1}}) begin miscompares++; $display("FAIL reset_segments: got %h want all ones", segments); end
        reset = 0;
    endtask
    task automatic test_run;
        int c, hi, lo;
        wait_mod(1, c);
        wait_mod(0, hi);
        wait_mod(1, lo);
        vectors++; if (hi !== 4) begin miscompares++; $display("FAIL run_high: got %0d want 4", hi); end
        vectors++; if (lo !== 4) begin miscompares++; $display("FAIL run_low: got %0d want 4", lo); end
        wait_mod(0, c);
        wait_mod(1, c);
        vectors++; if (cycle_count !== 32'd3) begin miscompares++; $display("FAIL run_count: got %0d want 3", cycle_count); end
    endtask
    task automatic test_pause;
        int c, r;
        pause = 1;
        wait_mod(0, c);
        vectors++; if (c > 4) begin miscompares++; $display("FAIL pause_fall: got %0d cycles want <= 4", c); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL pause_halted: got %b want 1", halted); end
        count_rises(100, r);
        vectors++; if (r !== 0) begin miscompares++; $display("FAIL pause_edges: got %0d want 0", r); end
        vectors++; if (cycle_count !== 32'd3) begin miscompares++; $display("FAIL pause_count: got %0d want 3", cycle_count); end
    endtask
    task automatic test_step;
        int r, hi;
        pulse_watch(2, 30, r, hi);
        vectors++; if (r !== 0) begin miscompares++; $display("FAIL glitch_edges: got %0d want 0", r); end
        pulse_watch(10, 40, r, hi);
        vectors++; if (r !== 1) begin miscompares++; $display("FAIL step_edges: got %0d want 1", r); end
        vectors++; if (hi !== 4) begin miscompares++; $display("FAIL step_high: got %0d want 4", hi); end
        vectors++; if (cycle_count !== 32'd4) begin miscompares++; $display("FAIL step_count: got %0d want 4", cycle_count); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL step_halted: got %b want 1", halted); end
    endtask
    task automatic test_display;
        logic [55:0] e;
        logic [1:0] sels [5] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
        sel = 1;
        ch1 = 32'h0123_89AF;
        ch2 = 32'hDEAD_BEEF;
        exp_q.push_back(seg_of(ch1));
        @(negedge clk);
        vectors++; if (segments[6:0] !== 7'h0E) begin miscompares++; $display("FAIL disp_digit0: got %h want 0e", segments[6:0]); end
        vectors++; if (segments[55:49] !== 7'h40) begin miscompares++; $display("FAIL disp_digit7: got %h want 40", segments[55:49]); end
        e = exp_q.pop_front();
        vectors++; if (segments !== e) begin miscompares++; $display("FAIL disp_sel1: got %h want %h", segments, e); end
        for (int i = 0; i < 5; i++) begin
            sel = sels[i];
            if (i == 3) ch1 = 32'h7654_3210;
            exp_q.push_back(seg_of(sel == 2'd1 ? ch1 : sel == 2'd2 ? ch2 : pc));
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++; if (segments !== e) begin miscompares++; $display("FAIL disp_sel%0d: got %h want %h", sel, segments, e); end
        end
    endtask
    task automatic test_breakpoint;
        int c, r, hi;
        reset = 1;
        pause = 0;
        bp_en = 1;
        bp_addr = 32'h10;
        repeat (2) @(negedge clk);
        reset = 0;
        wait_bp(c);
        vectors++; if (bp_hit !== 1'b1) begin miscompares++; $display("FAIL bp_trap: got %b want 1", bp_hit); end
        vectors++; if (cycle_count !== 32'd4) begin miscompares++; $display("FAIL bp_count: got %0d want 4", cycle_count); end
        vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL bp_pc: got %h want 10", pc); end
        count_rises(40, r);
        vectors++; if (r !== 0 || mod_clk !== 1'b0) begin miscompares++; $display("FAIL bp_stuck: got %0d edges mod_clk %b want 0 edges mod_clk 0", r, mod_clk); end
        pause = 1;
        repeat (8) @(negedge clk);
        vectors++; if (bp_hit !== 1'b0 || halted !== 1'b1) begin miscompares++; $display("FAIL bp_to_pause: got bp_hit %b halted %b want 0 1", bp_hit, halted); end
        pause = 0;
        count_rises(40, r);
        vectors++; if (r < 4) begin miscompares++; $display("FAIL bp_resume_edges: got %0d want >= 4", r); end
        vectors++; if (cycle_count !== 32'(4 + r)) begin miscompares++; $display("FAIL bp_resume_count: got %0d want %0d", cycle_count, 4 + r); end
        vectors++; if (bp_hit !== 1'b0) begin miscompares++; $display("FAIL bp_retrap: got %b want 0", bp_hit); end
        bp_addr = 32'h40;
        wait_bp(c);
        vectors++; if (bp_hit !== 1'b1 || cycle_count !== 32'd16) begin miscompares++; $display("FAIL bp2_trap: got bp_hit %b count %0d want 1 16", bp_hit, cycle_count); end
        pulse_watch(10, 40, r, hi);
        vectors++; if (r !== 1 || hi !== 4) begin miscompares++; $display("FAIL bp_step: got %0d edges %0d high want 1 4", r, hi); end
        vectors++; if (bp_hit !== 1'b1) begin miscompares++; $display("FAIL bp_step_hold: got %b want 1", bp_hit); end
        vectors++; if (cycle_count !== 32'd17 || pc !== 32'h44) begin miscompares++; $display("FAIL bp_step_count: got %0d pc %h want 17 44", cycle_count, pc); end
    endtask
    task automatic test_reset_in_step;
        int c;
        step_btn = 1;
        wait_mod(1, c);
        vectors++; if (c >= 300) begin miscompares++; $display("FAIL rst_step_start: got timeout want step"); end
        reset = 1;
        @(negedge clk);
        vectors++; if (mod_clk !== 1'b0 || bp_hit !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL rst_step_flags: got mod %b bp %b halted %b want 0 0 0", mod_clk, bp_hit, halted); end
        vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL rst_step_count: got %0d want 0", cycle_count); end
        vectors++; if (segments !== {56{1'b1}}) begin miscompares++; $display("FAIL rst_step_segments: got %h want all ones", segments); end
        step_btn = 0;
        reset = 0;
    endtask
    initial begin
        test_reset;
        test_run;
        test_pause;
        test_step;
        test_display;
        test_breakpoint;
        test_reset_in_step;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
